// File: rtl/pb_debouncer_bank_if.sv
// Button bank bundle: raw pins in, debounced levels and pulses out.
// The debouncer uses the slave modport; the pin/consumer side uses master.
interface pb_debouncer_bank_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] buttons;
  logic [NUM_CH-1:0] pb_state;
  logic [NUM_CH-1:0] pb_down;
  logic [NUM_CH-1:0] pb_up;
  logic [NUM_CH-1:0] pb_repeat;
  logic              pb_evt;

  modport master (
    output buttons,
    input  pb_state,
    input  pb_down,
    input  pb_up,
    input  pb_repeat,
    input  pb_evt
  );

  modport slave (
    input  buttons,
    output pb_state,
    output pb_down,
    output pb_up,
    output pb_repeat,
    output pb_evt
  );
endinterface

// File: rtl/pb_debouncer_bank.sv
// NUM_CH push-button debouncers with press/release/repeat pulses.
// Hold-to-repeat timers are built only when DEBOUNCE_REPEAT_EN is defined.
module pb_debouncer_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int RPT_W      = 22
) (
  input logic               clk,
  input logic               rst_n,
  pb_debouncer_bank_if.slave pb
);

  if (NUM_CH < 1 || NUM_CH > 32 || CNT_W < 1 || RPT_W < 1) begin : g_bad
    $error("pb_debouncer_bank: bad parameters");
  end

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] sync0;
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] state;
  logic [NUM_CH-1:0] down;
  logic [NUM_CH-1:0] up;
  logic [NUM_CH-1:0] rpt;
  logic [NUM_CH-1:0] flip;
  logic [NUM_CH-1:0] rpt_nx;
  logic              evt;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  assign raw = ACTIVE_LOW ? ~pb.buttons : pb.buttons;

  // A channel flips only after a full window of unbroken mismatch.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      flip[i] = (sync1[i] != state[i]) && (cnt[i] == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
      state <= '0;
      down  <= '0;
      up    <= '0;
      evt   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      state <= state ^ flip;
      down  <= flip & ~state;
      up    <= flip & state;
      evt   <= |{flip, rpt_nx};
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync1[i] == state[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  logic [RPT_W-1:0] tmr [NUM_CH];

  // Timer runs only while held; the toggle edge restarts it.
  always_comb begin
    rpt_nx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rpt_nx[i] = state[i] && !flip[i] && (tmr[i] == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tmr[i] <= '0;
      end
    end else begin
      rpt <= rpt_nx;
      for (int i = 0; i < NUM_CH; i++) begin
        if (flip[i] || !state[i]) begin
          tmr[i] <= '0;
        end else begin
          tmr[i] <= tmr[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  assign rpt_nx = '0;
  assign rpt    = '0;
`endif

  assign pb.pb_state  = state;
  assign pb.pb_down   = down;
  assign pb.pb_up     = up;
  assign pb.pb_repeat = rpt;
  assign pb.pb_evt    = evt;

endmodule

// File: tb/tb_pb_debouncer_bank.sv
// Directed bench for pb_debouncer_bank with a cycle-level reference model.
// Build with DEBOUNCE_REPEAT_EN to also check the repeat pulses.
module tb_pb_debouncer_bank;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int RW  = 5;
  localparam int WIN = 1 << CW;
  localparam int PER = 1 << RW;

  logic clk;
  logic rst_n;

  pb_debouncer_bank_if #(.NUM_CH(N)) bif ();

  pb_debouncer_bank #(
    .NUM_CH(N),
    .CNT_W(CW),
    .ACTIVE_LOW(1'b1),
    .RPT_W(RW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pb(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference model: raw pins pass two sample stages, a level change
  // is accepted after WIN consecutive mismatching samples.
  logic [N-1:0] ms0, ms1, mst, mdown, mup, mrep;
  logic         mevt;
  int           run  [N];
  int           hold [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms0 = '0; ms1 = '0; mst = '0;
      mdown = '0; mup = '0; mrep = '0;
      mevt = 1'b0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        mdown[i] = 1'b0;
        mup[i]   = 1'b0;
        mrep[i]  = 1'b0;
        if (ms1[i] != mst[i]) begin
          run[i]++;
          if (run[i] == WIN) begin
            run[i] = 0;
            mst[i] = ~mst[i];
            if (mst[i]) begin
              mdown[i] = 1'b1;
              hold[i] = 0;
            end else begin
              mup[i] = 1'b1;
            end
          end
        end else begin
          run[i] = 0;
        end
`ifdef DEBOUNCE_REPEAT_EN
        if (mst[i] && !mdown[i]) begin
          hold[i]++;
          if (hold[i] % PER == 0) mrep[i] = 1'b1;
        end
`endif
      end
      mevt = |{mdown, mup, mrep};
      ms1 = ms0;
      ms0 = ~bif.buttons;
    end
  end

  always @(negedge clk) begin
    chk("cycle",
        {15'd0, bif.pb_state, bif.pb_down, bif.pb_up,
         bif.pb_repeat, bif.pb_evt},
        {15'd0, mst, mdown, mup, mrep, mevt});
  end

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  task automatic outs_zero(input string nm);
    chk(nm,
        {15'd0, bif.pb_state, bif.pb_down, bif.pb_up,
         bif.pb_repeat, bif.pb_evt}, 32'd0);
  endtask

  int first;
  int cnt;
  int rcnt;
  int rpos [3];

  initial begin
    rst_n = 1'b0;
    bif.buttons = '1;
    // Reset held with noisy pins
    for (int i = 0; i < 20; i++) begin
      edge1();
      bif.buttons = 4'($urandom);
      if (i == 10) outs_zero("rst_hold");
    end
    bif.buttons = '1;
    edge1();
    rst_n = 1'b1;
    idle(5);
    outs_zero("rst_release");

    // Clean press of ch2: sample edge is the 1st, toggle on the 18th
    bif.buttons[2] = 1'b0;
    idle(18);
    chk("press_down", 32'(bif.pb_down), 32'h4);
    chk("press_state", 32'(bif.pb_state), 32'h4);
    edge1();
    chk("press_down_end", 32'(bif.pb_down), 32'h0);
    chk("press_state_hold", 32'(bif.pb_state), 32'h4);
    bif.buttons[2] = 1'b1;
    idle(20);

    // Bounce on ch0
    first = 0;
    cnt = 0;
    bif.buttons[0] = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      edge1();
      if (bif.pb_down[0]) begin
        cnt++;
        if (first == 0) first = n;
      end
      if (n == 10) bif.buttons[0] = 1'b1;
      if (n == 11) bif.buttons[0] = 1'b0;
    end
    chk("bounce_edge", 32'(first), 32'd29);
    chk("bounce_count", 32'(cnt), 32'd1);
    bif.buttons[0] = 1'b1;
    idle(20);

    // Simultaneous press ch0 / release ch1
    bif.buttons[1] = 1'b0;
    idle(20);
    bif.buttons[0] = 1'b0;
    bif.buttons[1] = 1'b1;
    idle(18);
    chk("sim_down", 32'(bif.pb_down), 32'h1);
    chk("sim_up", 32'(bif.pb_up), 32'h2);
    chk("sim_evt", 32'(bif.pb_evt), 32'h1);
    edge1();
    chk("sim_evt_end", 32'(bif.pb_evt), 32'h0);
    bif.buttons[0] = 1'b1;
    idle(20);

    // Hold ch3 for 100 cycles after its press pulse
    bif.buttons[3] = 1'b0;
    first = 0;
    for (int n = 1; n <= 30 && first == 0; n++) begin
      edge1();
      if (bif.pb_down[3]) first = n;
    end
    chk("rpt_down_seen", 32'(first), 32'd18);
    rcnt = 0;
    for (int n = 1; n <= 100; n++) begin
      edge1();
      if (bif.pb_repeat[3]) begin
        if (rcnt < 3) rpos[rcnt] = n;
        rcnt++;
      end
    end
`ifdef DEBOUNCE_REPEAT_EN
    chk("rpt_count", 32'(rcnt), 32'd3);
    if (rcnt == 3) begin
      chk("rpt_1", 32'(rpos[0]), 32'd32);
      chk("rpt_2", 32'(rpos[1]), 32'd64);
      chk("rpt_3", 32'(rpos[2]), 32'd96);
    end
`else
    chk("rpt_none", 32'(rcnt), 32'd0);
`endif
    bif.buttons[3] = 1'b1;
    cnt = 0;
    rcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      edge1();
      if (bif.pb_up[3]) cnt++;
      if (bif.pb_up[3] && bif.pb_repeat[3]) rcnt++;
      if (cnt > 0 && bif.pb_repeat[3]) rcnt++;
    end
    chk("rpt_up", 32'(cnt), 32'd1);
    chk("rpt_stop", 32'(rcnt), 32'd0);

    // Reset in mid-window on ch1
    bif.buttons[1] = 1'b0;
    idle(11);
    rst_n = 1'b0;
    #1;
    outs_zero("midrst_clear");
    idle(3);
    outs_zero("midrst_hold");
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 30 && first == 0; n++) begin
      edge1();
      if (bif.pb_down[1]) first = n;
    end
    chk("midrst_down", 32'(first), 32'd18);
    chk("midrst_state", 32'(bif.pb_state), 32'h2);
    bif.buttons[1] = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pb_debouncer_bank.md
# pb_debouncer_bank

Parametrised bank of NUM_CH independent push-button debouncers with two-flop synchronisers, a configurable debounce window, registered single-cycle press/release pulses and optional hold-to-repeat pulses. It sits between the board's raw button pins and the clock's control FSM, replacing per-button debouncer instances with one block. All channels share one clock and one reset.

## Interface
- NUM_CH, 4: number of button channels (1..32).
- CNT_W, 16: debounce counter width; debounce window is 2^CNT_W cycles of stable mismatch.
- ACTIVE_LOW, 1: 1 = raw input low means pressed (inverted before synchronisation); 0 = high means pressed.
- RPT_W, 22: repeat timer width; repeat period is 2^RPT_W cycles (used only with DEBOUNCE_REPEAT_EN).
- clk  input  1  system clock; all flops on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk at system level.
- buttons  input  NUM_CH  raw, asynchronous button levels.
- pb_state  output  NUM_CH  debounced level per channel, 1 = pressed.
- pb_down  output  NUM_CH  one-cycle pulse on debounced press.
- pb_up  output  NUM_CH  one-cycle pulse on debounced release.
- pb_repeat  output  NUM_CH  one-cycle pulse per repeat period while held.
- pb_evt  output  1  OR of all pb_down, pb_up, pb_repeat bits (registered alongside them).

## Operation
- Per channel: sync0 <= buttons[i] (inverted if ACTIVE_LOW); sync1 <= sync0. sync1 is the only input to the debounce logic.
- idle = (sync1 == pb_state[i]). If idle: cnt <= 0. Else: cnt <= cnt + 1; if cnt == all-ones: pb_state[i] toggles, cnt wraps to 0.
- Any single cycle with sync1 == pb_state (bounce) clears cnt; window restarts from 0.
- On the toggle edge: pb_down[i] <= 1 if new state is 1, pb_up[i] <= 1 if new state is 0; both otherwise 0. Never both in one cycle per channel.
- Channels fully independent; any number of bits may pulse in the same cycle.
- Reset: sync0, sync1, pb_state, cnt, repeat timer, pb_down, pb_up, pb_repeat, pb_evt all 0 immediately on rst_n low, regardless of clk. A button held through reset is treated as a fresh press afterwards (pb_down after one full window).

## Timing
- Input change sampled by sync0 at edge k: sync1 updates at k+1; pb_state toggles and pb_down/pb_up pulse at edge k+1+2^CNT_W, provided no bounce.
- Pulses last exactly one cycle; pb_evt asserts in the same cycle as the causing pulse.
- Repeat: timer clears on the pb_down edge; increments each cycle while pb_state[i] = 1; pb_repeat pulses on each edge where timer wraps from all-ones to 0, i.e. first repeat 2^RPT_W cycles after pb_down, then every 2^RPT_W cycles. Timer clears and repeats stop on the pb_up edge; no repeat pulse coincides with pb_up.
- No combinational path from buttons to any output.

## Configuration
- DEBOUNCE_REPEAT_EN defined: repeat timers per channel compiled in; pb_repeat behaves as above.
- DEBOUNCE_REPEAT_EN undefined: no repeat timers synthesised; pb_repeat tied to all-zero; RPT_W ignored; pb_evt reflects only pb_down/pb_up. Port list identical in both builds.

## Test plan
- Reset: hold rst_n = 0 with buttons toggling randomly -> all outputs 0 throughout; release with buttons all released -> outputs stay 0.
- Clean press, NUM_CH=4, CNT_W=4, ACTIVE_LOW=1: drive buttons[2] 1->0 before edge k -> pb_state[2] and pb_down[2] rise at edge k+17, pb_down[2] low at k+18; other channels unchanged.
- Bounce: press channel 0, release for 1 cycle at cycle 10 of window, press again -> no pb_down until 16 stable cycles after last bounce; exactly one pb_down total.
- Simultaneous: press ch0 and release ch1 (previously pressed) on same edge -> pb_down[0] and pb_up[1] pulse in same cycle; pb_evt = 1 for one cycle.
- Repeat (DEBOUNCE_REPEAT_EN, RPT_W=5): hold ch3 for 100 cycles after pb_down -> pb_repeat[3] at +32, +64, +96; release -> pb_up[3], no further repeats. Without macro -> pb_repeat stays 0.
- Reset mid-window: assert rst_n low at cnt = 9 with ch1 pressed -> outputs clear immediately; after release of reset with button still held -> pb_down[1] at 2 + 16 edges after first post-reset sample.
